// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, branch-select encodings and the
// fetch FSM state type used by fetch_unit and its PC sub-module.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_XOR   = 8'h06;
  localparam logic [7:0] OP_NOT   = 8'h07;
  localparam logic [7:0] OP_SHL   = 8'h08;
  localparam logic [7:0] OP_SHR   = 8'h09;
  localparam logic [7:0] OP_JMP   = 8'h0A;
  localparam logic [7:0] OP_BEQ   = 8'h0B;
  localparam logic [7:0] OP_BNE   = 8'h0C;
  localparam logic [7:0] OP_ROR   = 8'h0D;
  localparam logic [7:0] OP_MAX   = 8'h0D;

  localparam logic [1:0] BSEL_NEXT = 2'b00;
  localparam logic [1:0] BSEL_JUMP = 2'b01;
  localparam logic [1:0] BSEL_BEQ  = 2'b10;
  localparam logic [1:0] BSEL_BNE  = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // True for opcodes outside the defined instruction map.
  function automatic logic is_illegal_op(input logic [7:0] op);
    return op > OP_MAX;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// pc_next_calc: combinational next-PC selection.
// pc4 = pc + 4, tgt = pc4 + sign_ext(rd) * 4; all arithmetic wraps modulo 2^PC_W.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      rd,
  input  logic [1:0]      bselect,
  input  logic            alu_zero,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] tgt;

  assign pc4    = pc + {{(PC_W-3){1'b0}}, 3'b100};
  assign offset = {{(PC_W-10){rd[7]}}, rd, 2'b00};
  assign tgt    = pc4 + offset;

  // Select sequential or target address from the branch kind and zero flag.
  always_comb begin
    next_pc = pc4;
    case (bselect)
      BSEL_NEXT: next_pc = pc4;
      BSEL_JUMP: next_pc = tgt;
      BSEL_BEQ:  next_pc = alu_zero ? tgt : pc4;
      BSEL_BNE:  next_pc = alu_zero ? pc4 : tgt;
      default:   next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, fetches words over a
// req/ready handshake, presents decoded fields for one execute and retires
// on exec_done. Optional macro FETCH_ILLEGAL_TRAP_EN adds a sticky HALT on
// opcodes above OP_MAX; without it, illegal is tied low.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            instr_valid,
  output logic [7:0]      opcode,
  output logic [7:0]      rd,
  output logic [7:0]      rt,
  output logic [7:0]      rs_imm,
  input  logic            exec_done,
  input  logic [1:0]      bselect,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc,
  output logic            illegal
);

  fetch_state_t    state;
  logic [PC_W-1:0] next_pc;

  assign imem_addr = pc;

  pc_next_calc #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc       (pc),
    .rd       (rd),
    .bselect  (bselect),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

`ifndef FETCH_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  // Fetch FSM with registered handshake, field and PC outputs.
  // Reset leaves state=FETCH with imem_req low, so the first FETCH cycle after
  // reset only raises the request; retiring an instruction enters FETCH with
  // imem_req already high so imem_ready there completes in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      opcode      <= '0;
      rd          <= '0;
      rt          <= '0;
      rs_imm      <= '0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal     <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
            if (is_illegal_op(imem_rdata[31:24])) begin
              state    <= HALT;
              imem_req <= 1'b0;
              illegal  <= 1'b1;
            end else
`endif
            begin
              opcode      <= imem_rdata[31:24];
              rd          <= imem_rdata[23:16];
              rt          <= imem_rdata[15:8];
              rs_imm      <= imem_rdata[7:0];
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= ISSUE;
            end
          end else begin
            state <= WAIT;
          end
        end
        ISSUE: begin
          if (exec_done) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed boundary cases plus a
// randomized instruction stream checked against an arithmetic PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        instr_valid;
  logic [7:0]  opcode, rd, rt, rs_imm;
  logic        exec_done;
  logic [1:0]  bselect;
  logic        alu_zero;
  logic [31:0] pc;
  logic        illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] mpc;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rd          (rd),
    .rt          (rt),
    .rs_imm      (rs_imm),
    .exec_done   (exec_done),
    .bselect     (bselect),
    .alu_zero    (alu_zero),
    .pc          (pc),
    .illegal     (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference next-PC: taken branches land at (pc+4) + 4*signed offset words.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [7:0] off,
                                             input logic [1:0] bs, input logic z);
    int          words;
    logic [31:0] seq;
    logic [31:0] tgt;
    bit          taken;
    words = int'($signed(off));
    seq   = p + 32'd4;
    tgt   = seq + 32'(words * 4);
    taken = (bs == 2'd1) || (bs == 2'd2 && z) || (bs == 2'd3 && !z);
    return taken ? tgt : seq;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    imem_ready = 1'b0;
    exec_done  = 1'b0;
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_opcode", opcode, 0);
    reset_n = 1'b1;
    mpc     = 32'h0;
  endtask

  task automatic wait_req();
    int unsigned n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_up", imem_req, 1);
    check("addr", imem_addr, mpc);
  endtask

  task automatic run_instr(input logic [31:0] word, input int unsigned waits,
                           input int unsigned hold, input logic [1:0] bsel, input logic az);
    wait_req();
    for (int i = 0; i < int'(waits); i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      exec_done  = 1'($urandom);
      bselect    = 2'($urandom);
      tick();
      check("addr_stable", imem_addr, mpc);
      check("req_held", imem_req, 1);
      check("no_valid", instr_valid, 0);
      check("pc_hold_fetch", pc, mpc);
    end
    exec_done  = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("valid", instr_valid, 1);
    check("opcode", opcode, word[31:24]);
    check("rd", rd, word[23:16]);
    check("rt", rt, word[15:8]);
    check("rs_imm", rs_imm, word[7:0]);
    check("req_drop", imem_req, 0);
    for (int i = 0; i < int'(hold); i++) begin
      bselect  = 2'($urandom);
      alu_zero = 1'($urandom);
      tick();
      check("issue_hold", instr_valid, 1);
      check("opcode_hold", opcode, word[31:24]);
      check("pc_hold_issue", pc, mpc);
    end
    exec_done = 1'b1;
    bselect   = bsel;
    alu_zero  = az;
    tick();
    exec_done = 1'b0;
    mpc = model_next(mpc, word[23:16], bsel, az);
    check("pc_next", pc, mpc);
    check("valid_clr", instr_valid, 0);
    check("req_refetch", imem_req, 1);
    check("illegal_low", illegal, 0);
  endtask

  task automatic goto_20();
    do_reset();
    run_instr(32'h0A_07_00_00, 0, 0, 2'b01, 1'b0);
    check("at_20", pc, 32'h20);
  endtask

  initial begin
    imem_rdata = '0;
    imem_ready = 1'b0;
    exec_done  = 1'b0;
    bselect    = '0;
    alu_zero   = 1'b0;
    reset_n    = 1'b0;
    mpc        = '0;

    // Reset and first request.
    do_reset();
    tick();
    check("post_rst_req", imem_req, 1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_valid", instr_valid, 0);

    // Wait states, loadi r4,42.
    run_instr(32'h00_04_00_2A, 3, 1, 2'b00, 1'b0);
    check("t2_pc", pc, 32'h4);

    // Jumps around 0x10.
    run_instr(32'h0A_02_00_00, 0, 0, 2'b01, 1'b0);
    check("to_10", pc, 32'h10);
    run_instr(32'h0A_FE_00_00, 1, 0, 2'b01, 1'b0);
    check("jmp_back", pc, 32'h0C);
    run_instr(32'h01_00_01_02, 0, 0, 2'b00, 1'b1);
    check("back_10", pc, 32'h10);
    run_instr(32'h0A_7F_00_00, 2, 2, 2'b01, 1'b1);
    check("jmp_fwd", pc, 32'h210);

    // Branches at 0x20, offset +2 words.
    goto_20();
    run_instr(32'h0B_02_00_00, 0, 0, 2'b10, 1'b1);
    check("beq_t", pc, 32'h2C);
    goto_20();
    run_instr(32'h0B_02_00_00, 1, 1, 2'b10, 1'b0);
    check("beq_nt", pc, 32'h24);
    goto_20();
    run_instr(32'h0C_02_00_00, 0, 0, 2'b11, 1'b1);
    check("bne_nt", pc, 32'h24);
    goto_20();
    run_instr(32'h0C_02_00_00, 0, 2, 2'b11, 1'b0);
    check("bne_t", pc, 32'h2C);

    // Silent wrap at the bottom and top of the address space.
    do_reset();
    run_instr(32'h0A_FE_00_00, 0, 0, 2'b01, 1'b0);
    check("wrap_down", pc, 32'hFFFF_FFFC);
    run_instr(32'h02_01_02_03, 0, 0, 2'b00, 1'b0);
    check("wrap_up", pc, 32'h0);

    // Randomized stream.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] w;
      w = $urandom;
      w[31:24] = 8'($urandom_range(0, 13));
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), 2'($urandom), 1'($urandom));
    end

    // Reset mid-WAIT with a spurious exec_done.
    do_reset();
    run_instr(32'h0A_05_00_00, 0, 0, 2'b01, 1'b0);
    wait_req();
    imem_ready = 1'b0;
    tick();
    tick();
    reset_n   = 1'b0;
    exec_done = 1'b1;
    bselect   = 2'b01;
    tick();
    check("rw_pc", pc, 32'h0);
    check("rw_valid", instr_valid, 0);
    check("rw_req", imem_req, 0);
    reset_n   = 1'b1;
    exec_done = 1'b0;
    mpc       = 32'h0;

    // Reset mid-ISSUE coinciding with exec_done: no PC update.
    run_instr(32'h0A_05_00_00, 0, 0, 2'b01, 1'b0);
    wait_req();
    imem_ready = 1'b1;
    imem_rdata = 32'h0A_10_00_00;
    tick();
    imem_ready = 1'b0;
    check("ri_valid_pre", instr_valid, 1);
    reset_n   = 1'b0;
    exec_done = 1'b1;
    bselect   = 2'b01;
    tick();
    check("ri_pc", pc, 32'h0);
    check("ri_valid", instr_valid, 0);
    reset_n   = 1'b1;
    exec_done = 1'b0;
    tick();
    check("ri_pc_stay", pc, 32'h0);
    check("ri_req", imem_req, 1);
    mpc = 32'h0;

    // Unknown opcode 0x0E.
    run_instr(32'h02_03_00_00, 0, 0, 2'b01, 1'b0);
`ifdef FETCH_ILLEGAL_TRAP_EN
    wait_req();
    imem_ready = 1'b1;
    imem_rdata = 32'h0E_11_22_33;
    tick();
    check("trap_illegal", illegal, 1);
    check("trap_req", imem_req, 0);
    check("trap_valid", instr_valid, 0);
    for (int i = 0; i < 8; i++) begin
      imem_ready = 1'($urandom);
      exec_done  = 1'($urandom);
      bselect    = 2'($urandom);
      tick();
      check("halt_req", imem_req, 0);
      check("halt_illegal", illegal, 1);
      check("halt_pc", pc, mpc);
    end
    imem_ready = 1'b0;
    exec_done  = 1'b0;
`else
    run_instr(32'h0E_11_22_33, 1, 1, 2'b00, 1'b1);
    check("op0e_pc", pc, 32'h14);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
